// File: rtl/npu_out_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_out_writer_pkg
// Description : Shared NPU write-back definitions: state encoding constants
//               for the output writer FSM and the lane-index width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package npu_out_writer_pkg;

    // State encoding for the output writer FSM.
    localparam int c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle    = 2'd0;
    localparam logic [c_state_w-1:0] c_st_collect = 2'd1;
    localparam logic [c_state_w-1:0] c_st_done    = 2'd2;

    // Lane index width for the default pack factor of 4 words per memory word.
    localparam int NPU_PACK_DEFAULT = 4;
    localparam int LANE_W           = $clog2(NPU_PACK_DEFAULT);

    // Lane index width for an arbitrary power-of-two pack factor (>= 2).
    function automatic int npu_lane_w(input int pack);
        return $clog2(pack);
    endfunction

endpackage : npu_out_writer_pkg
`default_nettype wire

// File: rtl/npu_pack_reg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pack_reg
// Description : Lane buffer that packs PACK serial words into one wide word.
//               Lane 0 holds the earliest word. The buffer is zeroed whenever
//               it is flushed or cleared, so a partially filled pack always
//               carries zeros in its unused upper lanes.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               i_capture      - store i_data into lane o_idx, advance index
//               i_flush        - pack has been emitted; zero lanes, index 0
//               i_clear        - layer start; zero lanes, index 0
//               i_data         - incoming result word
//               o_idx          - lane the next capture will write
//               o_pack_next    - buffer contents including this cycle's capture
// Revision    : 1.0 - initial release
// ============================================================================
module npu_pack_reg
    import npu_out_writer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PACK   = 4,
    localparam int c_lane_w = npu_lane_w(PACK)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_capture,
    input  logic                   i_flush,
    input  logic                   i_clear,
    input  logic [DATA_W-1:0]      i_data,
    output logic [c_lane_w-1:0]    o_idx,
    output logic [PACK*DATA_W-1:0] o_pack_next
);

    logic [PACK-1:0][DATA_W-1:0] r_lanes;
    logic [c_lane_w-1:0]         r_idx;
    logic [PACK-1:0][DATA_W-1:0] w_pack;

    // Merge the word being captured this cycle so the writer can emit a pack
    // on the same edge that completes it.
    always_comb begin
        w_pack = r_lanes;
        if (i_capture) begin
            w_pack[r_idx] = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear || i_flush) begin
            r_lanes <= '0;
            r_idx   <= '0;
        end else if (i_capture) begin
            r_lanes[r_idx] <= i_data;
            r_idx          <= r_idx + c_lane_w'(1);
        end
    end

    assign o_idx       = r_idx;
    assign o_pack_next = w_pack;

endmodule : npu_pack_reg
`default_nettype wire

// File: rtl/npu_out_writer.sv
`default_nettype none
// ============================================================================
// Module      : npu_out_writer
// Description : NPU write-back stage. Packs PACK serial result words into one
//               SRAM word, writes it at an auto-incrementing address, flushes
//               partial packs at each burst end and pulses layer_done once the
//               programmed number of bursts has been written.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               enable            - global step enable; low freezes all state
//               start             - layer start (honoured in IDLE only)
//               base_addr         - first write address, latched on start
//               num_bursts        - bursts in the layer, latched on start
//               wr_en, data_in    - serial result word strobe and data
//               out_done          - last cycle of a sequencer burst
//               mem_we            - SRAM write strobe (one cycle per write)
//               mem_addr          - SRAM write address
//               mem_wdata         - packed data, lane 0 in the low bits
//               busy              - high in COLLECT and DONE
//               layer_done        - one-cycle pulse at layer completion
//               err               - sticky error (wrap, stray strobes in IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
module npu_out_writer
    import npu_out_writer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PACK   = 4,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [CNT_W-1:0]       num_bursts,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   out_done,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [PACK*DATA_W-1:0] mem_wdata,
    output logic                   busy,
    output logic                   layer_done,
    output logic                   err
);

    localparam int c_lane_w = npu_lane_w(PACK);

    logic [c_state_w-1:0]   r_state;
    logic [c_state_w-1:0]   w_state_next;
    logic [ADDR_W-1:0]      r_addr;
    logic [CNT_W-1:0]       r_limit;
    logic [CNT_W-1:0]       r_count;
    logic                   r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [PACK*DATA_W-1:0] r_mem_wdata;
    logic                   r_err;

    logic                   w_in_idle;
    logic                   w_in_collect;
    logic                   w_start;
    logic                   w_capture;
    logic                   w_full;
    logic                   w_burst_end;
    logic                   w_flush;
    logic                   w_write;
    logic                   w_last_burst;
    logic [c_lane_w-1:0]    w_idx;
    logic [PACK*DATA_W-1:0] w_pack;

    assign w_in_idle    = (r_state == c_st_idle);
    assign w_in_collect = (r_state == c_st_collect);
    assign w_start      = w_in_idle && enable && start;
    assign w_capture    = w_in_collect && enable && wr_en;
    assign w_burst_end  = w_in_collect && enable && out_done;

    // A capture into the top lane always completes a pack. On a burst-end
    // cycle that same write doubles as the flush, so the flush is only
    // raised when leftover lanes remain and no full write is already going.
    assign w_full       = w_capture && (w_idx == c_lane_w'(PACK - 1));
    assign w_flush      = w_burst_end && !w_full && (w_capture || (w_idx != '0));
    assign w_write      = w_full || w_flush;
    assign w_last_burst = w_burst_end && ((r_count + CNT_W'(1)) == r_limit);

    npu_pack_reg #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_pack (
        .clk         (clk),
        .reset       (reset),
        .i_capture   (w_capture),
        .i_flush     (w_write),
        .i_clear     (w_start),
        .i_data      (data_in),
        .o_idx       (w_idx),
        .o_pack_next (w_pack)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (enable && start) begin
                    w_state_next = (num_bursts == '0) ? c_st_done : c_st_collect;
                end
            end
            c_st_collect: begin
                if (w_last_burst) begin
                    w_state_next = c_st_done;
                end
            end
            // DONE lasts exactly one cycle whatever enable does.
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Address / burst counters and registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_limit     <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            // The strobe is a single-cycle pulse; it falls whenever no new
            // write is issued, including every cycle with enable low.
            r_mem_we <= 1'b0;

            if (w_start) begin
                r_addr  <= base_addr;
                r_limit <= num_bursts;
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_in_idle && enable && (wr_en || out_done)) begin
                r_err <= 1'b1;
            end

            if (w_write) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_pack;
                r_addr      <= r_addr + ADDR_W'(1);
                if (&r_addr) begin
                    r_err <= 1'b1;
                end
            end

            if (w_burst_end) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign err        = r_err;
    assign busy       = (r_state != c_st_idle);
    assign layer_done = (r_state == c_st_done);

endmodule : npu_out_writer
`default_nettype wire
